// File: rtl/db_arbiter.sv
// rtl/db_arbiter.sv - two-master round-robin data bus arbiter with lock and slave timeout
module db_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CW      = 8
) (
  input  logic        clk,
  input  logic        res,
  input  logic [1:0]  m0_accessType,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_dataOut,
  input  logic        m0_lock,
  output logic [31:0] m0_dataIn,
  output logic        m0_ready,
  output logic        m0_err,
  input  logic [1:0]  m1_accessType,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_dataOut,
  input  logic        m1_lock,
  output logic [31:0] m1_dataIn,
  output logic        m1_ready,
  output logic        m1_err,
  output logic [1:0]  s_accessType,
  output logic [31:0] s_addr,
  output logic [31:0] s_dataOut,
  input  logic [31:0] s_dataIn,
  input  logic        s_ready,
  output logic        grant,
  output logic        busy
);

  localparam logic [1:0] ACC_NONE = 2'd0;

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t        state, state_d;
  logic          last, last_d, grant_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          err0_d, err1_d;

  logic          req0, req1;
  logic [1:0]    g_type;
  logic          g_lock;
  logic          complete;

  assign req0   = (m0_accessType != ACC_NONE);
  assign req1   = (m1_accessType != ACC_NONE);
  assign g_type = grant ? m1_accessType : m0_accessType;
  assign g_lock = grant ? m1_lock : m0_lock;

  // Read data is broadcast; each master qualifies it with its own ready.
  assign m0_dataIn = s_dataIn;
  assign m1_dataIn = s_dataIn;

  assign complete = (state == S_GRANT) && !res && s_ready && (g_type != ACC_NONE);

  always_ff @(posedge clk) begin
    if (res) begin
      state  <= S_IDLE;
      grant  <= 1'b0;
      last   <= 1'b1;
      cnt    <= '0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
    end else begin
      state  <= state_d;
      grant  <= grant_d;
      last   <= last_d;
      cnt    <= cnt_d;
      m0_err <= err0_d;
      m1_err <= err1_d;
    end
  end

  always_comb begin
    state_d      = state;
    grant_d      = grant;
    last_d       = last;
    cnt_d        = cnt;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    s_accessType = ACC_NONE;
    s_addr       = grant ? m1_addr : m0_addr;
    s_dataOut    = grant ? m1_dataOut : m0_dataOut;
    m0_ready     = complete && !grant;
    m1_ready     = complete && grant;
    busy         = (state == S_GRANT) && !res;

    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          grant_d = (req0 && req1) ? ~last : req1;
          cnt_d   = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!res) s_accessType = g_type;
        if (g_type == ACC_NONE) begin
          if (g_lock) cnt_d = '0;
          else        state_d = S_IDLE;
        end else if (s_ready) begin
          // Completion beats a coincident timeout expiry.
          last_d = grant;
          cnt_d  = '0;
          if (!g_lock) state_d = S_IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          err0_d  = !grant;
          err1_d  = grant;
          last_d  = grant;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_db_arbiter.sv
// tb/tb_db_arbiter.sv - directed self-checking bench for db_arbiter
module tb_db_arbiter;

  localparam logic [1:0] NONE = 2'd0, RD = 2'd1, WR = 2'd2;

  logic        clk = 1'b0;
  logic        res;
  logic [1:0]  m0_accessType, m1_accessType;
  logic [31:0] m0_addr, m0_dataOut, m1_addr, m1_dataOut;
  logic        m0_lock, m1_lock;
  logic [31:0] m0_dataIn, m1_dataIn;
  logic        m0_ready, m0_err, m1_ready, m1_err;
  logic [1:0]  s_accessType;
  logic [31:0] s_addr, s_dataOut, s_dataIn;
  logic        s_ready;
  logic        grant, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  db_arbiter #(.TIMEOUT(8), .CW(4)) dut (
    .clk(clk), .res(res),
    .m0_accessType(m0_accessType), .m0_addr(m0_addr), .m0_dataOut(m0_dataOut),
    .m0_lock(m0_lock), .m0_dataIn(m0_dataIn), .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_accessType(m1_accessType), .m1_addr(m1_addr), .m1_dataOut(m1_dataOut),
    .m1_lock(m1_lock), .m1_dataIn(m1_dataIn), .m1_ready(m1_ready), .m1_err(m1_err),
    .s_accessType(s_accessType), .s_addr(s_addr), .s_dataOut(s_dataOut),
    .s_dataIn(s_dataIn), .s_ready(s_ready), .grant(grant), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    res = 1'b1;
    step();
    step();
    res = 1'b0;
    settle();
  endtask

  initial begin
    res = 1'b1;
    m0_accessType = NONE; m0_addr = '0; m0_dataOut = '0; m0_lock = 1'b0;
    m1_accessType = NONE; m1_addr = '0; m1_dataOut = '0; m1_lock = 1'b0;
    s_dataIn = '0; s_ready = 1'b0;
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_stype", s_accessType, NONE);
    chk("rst_err0", m0_err, 0);
    chk("rst_err1", m1_err, 0);

    // Single read
    m0_accessType = RD; m0_addr = 32'h1000; settle();
    chk("rd_c0_stype", s_accessType, NONE);
    step();
    chk("rd_c1_stype", s_accessType, RD);
    chk("rd_c1_addr", s_addr, 32'h1000);
    chk("rd_c1_busy", busy, 1);
    step();
    chk("rd_c2_ready", m0_ready, 0);
    step();
    s_ready = 1'b1; s_dataIn = 32'hDEADBEEF; settle();
    chk("rd_c3_ready", m0_ready, 1);
    chk("rd_c3_data", m0_dataIn, 32'hDEADBEEF);
    chk("rd_c3_m1ready", m1_ready, 0);
    step();
    s_ready = 1'b0; m0_accessType = NONE; settle();
    chk("rd_c4_busy", busy, 0);
    chk("rd_c4_ready", m0_ready, 0);

    // Contention after reset: 0,1,0,1 with idle cycles between
    do_reset();
    m0_accessType = RD; m1_accessType = RD; m1_addr = 32'h2000; s_ready = 1'b1; settle();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_busy", busy, 1);
      chk("rr_grant", grant, i % 2);
      chk("rr_ready0", m0_ready, (i % 2 == 0));
      chk("rr_ready1", m1_ready, (i % 2 == 1));
      step();
      chk("rr_idle_busy", busy, 0);
      chk("rr_idle_ready0", m0_ready, 0);
    end
    m0_accessType = NONE; m1_accessType = NONE; s_ready = 1'b0;
    step();

    // Locked read-modify-write by m0 with m1 pending (last=1, so m0 wins)
    m0_accessType = RD; m0_lock = 1'b1; m1_accessType = RD; settle();
    step();
    chk("rmw_grant", grant, 0);
    chk("rmw_stype_r", s_accessType, RD);
    s_ready = 1'b1; settle();
    chk("rmw_r_ready", m0_ready, 1);
    step();
    m0_accessType = WR; m0_lock = 1'b0; s_ready = 1'b0; settle();
    chk("rmw_hold_busy", busy, 1);
    chk("rmw_hold_grant", grant, 0);
    chk("rmw_stype_w", s_accessType, WR);
    step();
    chk("rmw_wait_stype", s_accessType, WR);
    s_ready = 1'b1; settle();
    chk("rmw_w_ready", m0_ready, 1);
    chk("rmw_m1_ready", m1_ready, 0);
    step();
    m0_accessType = NONE; s_ready = 1'b0; settle();
    chk("rmw_idle_busy", busy, 0);
    step();
    chk("rmw_m1_grant", grant, 1);
    chk("rmw_m1_stype", s_accessType, RD);
    chk("rmw_m1_addr", s_addr, 32'h2000);
    s_ready = 1'b1; settle();
    chk("rmw_m1_ready", m1_ready, 1);
    step();
    m1_accessType = NONE; s_ready = 1'b0;
    step();

    // Timeout on m1 write, m0 pending behind it
    m1_accessType = WR; settle();
    step();
    chk("to_grant", grant, 1);
    m0_accessType = RD;
    for (int i = 1; i < 8; i++) begin
      step();
      chk("to_wait_err", m1_err, 0);
      chk("to_wait_busy", busy, 1);
    end
    step();
    chk("to_err1", m1_err, 1);
    chk("to_err0", m0_err, 0);
    chk("to_stype", s_accessType, NONE);
    chk("to_busy", busy, 0);
    m1_accessType = NONE;
    step();
    chk("to_pulse", m1_err, 0);
    chk("to_next_grant", grant, 0);
    chk("to_next_stype", s_accessType, RD);
    s_ready = 1'b1; settle();
    chk("to_next_ready", m0_ready, 1);
    step();
    m0_accessType = NONE; s_ready = 1'b0;
    step();

    // Withdrawal without lock
    m0_accessType = RD; settle();
    step();
    chk("wd_busy", busy, 1);
    m0_accessType = NONE; s_ready = 1'b1; settle();
    chk("wd_stype", s_accessType, NONE);
    chk("wd_ready", m0_ready, 0);
    step();
    s_ready = 1'b0; settle();
    chk("wd_idle", busy, 0);
    chk("wd_err", m0_err, 0);

    // Withdrawal with lock: grant held, counter restarted, timeout still forfeits lock
    m0_accessType = RD; m0_lock = 1'b1; settle();
    for (int i = 0; i < 4; i++) step();
    m0_accessType = NONE; settle();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("wdl_busy", busy, 1);
      chk("wdl_err", m0_err, 0);
    end
    m0_accessType = RD; settle();
    for (int i = 1; i < 8; i++) begin
      step();
      chk("wdl_cnt_err", m0_err, 0);
    end
    step();
    chk("wdl_to_err", m0_err, 1);
    chk("wdl_to_busy", busy, 0);
    m0_accessType = NONE; m0_lock = 1'b0;
    step();

    // Reset during an m1 transfer
    m1_accessType = RD; settle();
    step();
    chk("mr_grant", grant, 1);
    step();
    res = 1'b1;
    step();
    res = 1'b0; settle();
    chk("mr_stype", s_accessType, NONE);
    chk("mr_busy", busy, 0);
    chk("mr_grant0", grant, 0);
    chk("mr_ready", m1_ready, 0);
    chk("mr_err", m1_err, 0);
    m0_accessType = RD;
    step();
    chk("mr_tie_grant", grant, 0);
    chk("mr_tie_stype", s_accessType, RD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
